// File: rtl/jk_excitation_driver_if.sv
// rtl/jk_excitation_driver_if.sv - handshake/excitation bundle for the JK excitation driver
interface jk_excitation_driver_if #(
  parameter int LEN  = 8,
  parameter int ERRW = 4
);
  logic            load;
  logic [LEN-1:0]  pattern;
  logic            start;
  logic            abort;
  logic            q_fb;
  logic            J;
  logic            K;
  logic            T;
  logic            busy;
  logic            done;
  logic [ERRW-1:0] err_cnt;

  modport master (
    output load, pattern, start, abort, q_fb,
    input  J, K, T, busy, done, err_cnt
  );

  modport slave (
    input  load, pattern, start, abort, q_fb,
    output J, K, T, busy, done, err_cnt
  );
endinterface

// File: rtl/jk_excitation_driver.sv
// rtl/jk_excitation_driver.sv - drives J/K/T to walk an external flip-flop through a stored Q pattern
// and counts how often the fed-back Q missed the value requested one cycle earlier.
module jk_excitation_driver #(
  parameter int LEN  = 8,
  parameter int ERRW = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  jk_excitation_driver_if.slave bus
);
  localparam int IDXW = (LEN > 2) ? $clog2(LEN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [LEN-1:0]    pattern_q, pattern_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              exp_q_q, exp_q_d;
  logic              chk_valid_q, chk_valid_d;
  logic [ERRW-1:0]   err_cnt_q, err_cnt_d;

  logic tgt;
  logic last_step;
  logic mismatch;
  logic err_sat;

  assign tgt       = pattern_q[idx_q];
  assign last_step = (idx_q == IDXW'(LEN - 1));
  assign mismatch  = chk_valid_q & (bus.q_fb ^ exp_q_q);
  assign err_sat   = &err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN: begin
        if (bus.abort)      state_d = S_IDLE;
        else if (last_step) state_d = S_FLUSH;
      end
      S_FLUSH: state_d = bus.abort ? S_IDLE : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.J    = 1'b0;
    bus.K    = 1'b0;
    bus.T    = 1'b0;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_q)
      S_RUN: begin
        bus.J    = ~bus.q_fb & tgt;
        bus.K    = bus.q_fb & ~tgt;
        bus.T    = bus.q_fb ^ tgt;
        bus.busy = 1'b1;
      end
      S_FLUSH: bus.busy = 1'b1;
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end
  assign bus.err_cnt = err_cnt_q;

  // exp_q lags the excitation by one cycle, so the check in cycle k grades the target of cycle k-1.
  always_comb begin
    pattern_d   = pattern_q;
    idx_d       = idx_q;
    exp_q_d     = exp_q_q;
    chk_valid_d = chk_valid_q;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.load) pattern_d = bus.pattern;
        if (bus.start) begin
          idx_d       = '0;
          chk_valid_d = 1'b0;
          err_cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          idx_d       = '0;
          chk_valid_d = 1'b0;
        end else begin
          exp_q_d     = tgt;
          chk_valid_d = 1'b1;
          idx_d       = last_step ? '0 : idx_q + IDXW'(1);
          if (mismatch && !err_sat) err_cnt_d = err_cnt_q + ERRW'(1);
        end
      end
      S_FLUSH: begin
        chk_valid_d = 1'b0;
        if (!bus.abort && mismatch && !err_sat) err_cnt_d = err_cnt_q + ERRW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q   <= '0;
      idx_q       <= '0;
      exp_q_q     <= 1'b0;
      chk_valid_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      pattern_q   <= pattern_d;
      idx_q       <= idx_d;
      exp_q_q     <= exp_q_d;
      chk_valid_q <= chk_valid_d;
      err_cnt_q   <= err_cnt_d;
    end
  end
endmodule

// File: tb/tb_jk_excitation_driver.sv
// tb/tb_jk_excitation_driver.sv - randomized self-checking bench with a JK flip-flop plant and a
// per-run reference model of excitation and mismatch counting.
module tb_jk_excitation_driver;
  localparam int LEN = 8;

  logic clk;
  logic rst;
  logic load_r, start_r, abort_r;
  logic [LEN-1:0] pat_r;
  logic noise, stuck, preset;
  logic q_ff;
  int   checks;
  int   errors;
  int   last_err;

  jk_excitation_driver_if #(.LEN(LEN), .ERRW(4)) bus ();
  jk_excitation_driver_if #(.LEN(LEN), .ERRW(2)) bus2 ();

  jk_excitation_driver #(.LEN(LEN), .ERRW(4)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  jk_excitation_driver #(.LEN(LEN), .ERRW(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus.load     = load_r;
  assign bus.pattern  = pat_r;
  assign bus.start    = start_r;
  assign bus.abort    = abort_r;
  assign bus.q_fb     = stuck ? 1'b0 : (q_ff ^ noise);
  assign bus2.load    = load_r;
  assign bus2.pattern = pat_r;
  assign bus2.start   = start_r;
  assign bus2.abort   = abort_r;
  assign bus2.q_fb    = bus.q_fb;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // JK flip-flop plant driven by the first instance.
  always_ff @(posedge clk) begin
    if (rst) q_ff <= 1'b0;
    else if (preset) q_ff <= 1'b1;
    else begin
      case ({bus.J, bus.K})
        2'b10:   q_ff <= 1'b1;
        2'b01:   q_ff <= 1'b0;
        2'b11:   q_ff <= ~q_ff;
        default: q_ff <= q_ff;
      endcase
    end
  end

  task automatic run_pattern(input logic [LEN-1:0] pat, input bit do_load, input bit use_noise,
                             input bit abort_at_start);
    int model_err;
    logic cur, tgt, e_j, e_k, e_t, e_busy, e_done;
    int e_err4, e_err2;
    model_err = 0;
    @(negedge clk);
    load_r = do_load; pat_r = pat; start_r = 1'b1; abort_r = abort_at_start; noise = 1'b0;
    @(posedge clk);
    for (int c = 0; c <= LEN + 2; c++) begin
      @(negedge clk);
      load_r = 1'b0; start_r = 1'b0; abort_r = 1'b0;
      noise = (use_noise && c <= LEN) ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      cur = bus.q_fb;
      tgt = (c < LEN) ? pat[c] : 1'b0;
      e_j = (c < LEN) ? (~cur & tgt) : 1'b0;
      e_k = (c < LEN) ? (cur & ~tgt) : 1'b0;
      e_t = (c < LEN) ? (cur ^ tgt) : 1'b0;
      e_busy = (c <= LEN);
      e_done = (c == LEN + 1);
      e_err4 = (model_err > 15) ? 15 : model_err;
      e_err2 = (model_err > 3) ? 3 : model_err;
      checks += 7;
      if (bus.J !== e_j) begin errors++; $display("FAIL run_J c=%0d got %0b exp %0b", c, bus.J, e_j); end
      if (bus.K !== e_k) begin errors++; $display("FAIL run_K c=%0d got %0b exp %0b", c, bus.K, e_k); end
      if (bus.T !== e_t) begin errors++; $display("FAIL run_T c=%0d got %0b exp %0b", c, bus.T, e_t); end
      if (bus.busy !== e_busy) begin errors++; $display("FAIL run_busy c=%0d got %0b exp %0b", c, bus.busy, e_busy); end
      if (bus.done !== e_done) begin errors++; $display("FAIL run_done c=%0d got %0b exp %0b", c, bus.done, e_done); end
      if (int'(bus.err_cnt) != e_err4) begin errors++; $display("FAIL run_err c=%0d got %0d exp %0d", c, bus.err_cnt, e_err4); end
      if (int'(bus2.err_cnt) != e_err2) begin errors++; $display("FAIL run_err_sat c=%0d got %0d exp %0d", c, bus2.err_cnt, e_err2); end
      if (c >= 1 && c <= LEN && cur != pat[c-1]) model_err++;
    end
    noise = 1'b0;
    last_err = model_err;
  endtask

  task automatic test_reset();
    rst = 1'b1; load_r = 1'b1; start_r = 1'b1; pat_r = 8'h5A; abort_r = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      checks += 6;
      if (bus.J !== 1'b0) begin errors++; $display("FAIL reset_J got %0b exp 0", bus.J); end
      if (bus.K !== 1'b0) begin errors++; $display("FAIL reset_K got %0b exp 0", bus.K); end
      if (bus.T !== 1'b0) begin errors++; $display("FAIL reset_T got %0b exp 0", bus.T); end
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", bus.busy); end
      if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", bus.done); end
      if (bus.err_cnt !== 4'd0) begin errors++; $display("FAIL reset_err got %0d exp 0", bus.err_cnt); end
    end
    rst = 1'b0; load_r = 1'b0; start_r = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_alternating();
    run_pattern(8'b10101010, 1'b1, 1'b0, 1'b0);
    checks++;
    if (last_err != 0) begin errors++; $display("FAIL alt_err got %0d exp 0", last_err); end
  endtask

  task automatic test_all_ones_preset();
    @(negedge clk); preset = 1'b1;
    @(negedge clk); preset = 1'b0;
    run_pattern(8'hFF, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_stuck_low();
    stuck = 1'b1;
    run_pattern(8'hFF, 1'b1, 1'b0, 1'b0);
    stuck = 1'b0;
    checks++;
    if (last_err != 8) begin errors++; $display("FAIL stuck_model got %0d exp 8", last_err); end
  endtask

  task automatic test_abort_ignored();
    logic [LEN-1:0] a;
    a = LEN'($urandom);
    @(negedge clk); load_r = 1'b1; pat_r = a; start_r = 1'b1;
    @(posedge clk);
    @(negedge clk); load_r = 1'b0; start_r = 1'b0;
    @(negedge clk); noise = 1'b1; load_r = 1'b1; pat_r = ~a; start_r = 1'b1;
    @(negedge clk); noise = 1'b0; load_r = 1'b0; start_r = 1'b0; abort_r = 1'b1;
    @(negedge clk); abort_r = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks += 4;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy c=%0d got %0b exp 0", c, bus.busy); end
      if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done c=%0d got %0b exp 0", c, bus.done); end
      if ({bus.J, bus.K, bus.T} !== 3'b000) begin errors++; $display("FAIL abort_jkt c=%0d got %03b exp 000", c, {bus.J, bus.K, bus.T}); end
      if (bus.err_cnt !== 4'd1) begin errors++; $display("FAIL abort_err c=%0d got %0d exp 1", c, bus.err_cnt); end
      @(negedge clk);
    end
    run_pattern(a, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_rst_during_run();
    logic [LEN-1:0] b;
    b = LEN'($urandom);
    @(negedge clk); load_r = 1'b1; pat_r = b; start_r = 1'b1;
    @(posedge clk);
    @(negedge clk); load_r = 1'b0; start_r = 1'b0; noise = 1'b1;
    @(negedge clk); noise = 1'b0;
    @(negedge clk); rst = 1'b1; load_r = 1'b1; start_r = 1'b1; pat_r = LEN'($urandom);
    @(negedge clk); rst = 1'b0; load_r = 1'b0; start_r = 1'b0;
    #1;
    checks += 4;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_run_busy got %0b exp 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_run_done got %0b exp 0", bus.done); end
    if ({bus.J, bus.K, bus.T} !== 3'b000) begin errors++; $display("FAIL rst_run_jkt got %03b exp 000", {bus.J, bus.K, bus.T}); end
    if (bus.err_cnt !== 4'd0) begin errors++; $display("FAIL rst_run_err got %0d exp 0", bus.err_cnt); end
    run_pattern('0, 1'b0, 1'b0, 1'b0);
    run_pattern(LEN'($urandom), 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_idle_abort();
    @(negedge clk); abort_r = 1'b1;
    repeat (2) begin
      @(negedge clk); #1;
      checks += 2;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_abort_busy got %0b exp 0", bus.busy); end
      if (int'(bus.err_cnt) != last_err) begin errors++; $display("FAIL idle_abort_err got %0d exp %0d", bus.err_cnt, last_err); end
    end
    abort_r = 1'b0;
    run_pattern(LEN'($urandom), 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back_random();
    for (int r = 0; r < 8; r++) begin
      stuck = ($urandom_range(0, 3) == 0);
      run_pattern(LEN'($urandom), 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      stuck = 1'b0;
    end
  endtask

  initial begin
    checks = 0; errors = 0; last_err = 0;
    rst = 1'b1; load_r = 1'b0; start_r = 1'b0; abort_r = 1'b0; pat_r = '0;
    noise = 1'b0; stuck = 1'b0; preset = 1'b0;
    test_reset();
    test_alternating();
    test_all_ones_preset();
    test_stuck_low();
    test_abort_ignored();
    test_rst_during_run();
    test_idle_abort();
    test_back_to_back_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
